// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with valid/ready handshakes.
// Denormals are flushed to zero. Rounding is to nearest, ties to even, using guard/round/sticky.
//
// state   | meaning
// IDLE    | waiting for operands; in_ready=1
// UNPACK  | classify operands, resolve special values
// ALIGN   | swap so X has the larger magnitude, shift Y right into G/R/S
// ADD     | add or subtract the aligned mantissas
// NORM    | renormalise after carry or cancellation, detect underflow
// ROUND   | nearest-even rounding, overflow detection
// DONE    | result presented until out_ready
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] op_a,
   input  logic [EXP_W+MAN_W:0] op_b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 invalid
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int MW4  = MAN_W + 4;
   localparam int SH_W = $clog2(MW4 + 1);
   localparam int EW1  = EXP_W + 1;
   localparam logic [EXP_W-1:0] ONES  = '1;
   localparam logic [EW1-1:0]   E_ONE = 1;
   localparam logic [W-1:0]     QNAN  = {1'b0, ONES, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t            state;
   logic [W-1:0]      a_q, b_q;
   logic              sign_r, eff_sub, uf_r;
   logic [EW1-1:0]    exp_r;
   logic [MW4-1:0]    x_m, y_m, norm_m;
   logic [MW4:0]      sum_r;

   function automatic logic [SH_W-1:0] lzc(input logic [MW4-1:0] v);
      lzc = SH_W'(MW4);
      for (int i = 0; i < MW4; i++)
         if (v[i]) lzc = SH_W'(MW4 - 1 - i);
   endfunction

   // Operand classification (b_q already carries the effective sign)
   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign sa     = a_q[W-1];
   assign sb     = b_q[W-1];
   assign ea     = a_q[W-2:MAN_W];
   assign eb     = b_q[W-2:MAN_W];
   assign fa     = a_q[MAN_W-1:0];
   assign fb     = b_q[MAN_W-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == ONES) && (fa == '0);
   assign b_inf  = (eb == ONES) && (fb == '0);
   assign a_nan  = (ea == ONES) && (fa != '0);
   assign b_nan  = (eb == ONES) && (fb != '0);

   logic         special, special_inv;
   logic [W-1:0] special_res;

   always_comb begin
      special     = 1'b1;
      special_inv = 1'b0;
      special_res = QNAN;
      if (a_nan || b_nan)
         special_res = QNAN;
      else if (a_inf && b_inf) begin
         if (sa != sb) special_inv = 1'b1;
         else          special_res = {sa, ONES, {MAN_W{1'b0}}};
      end
      else if (a_inf)
         special_res = {sa, ONES, {MAN_W{1'b0}}};
      else if (b_inf)
         special_res = {sb, ONES, {MAN_W{1'b0}}};
      else if (a_zero && b_zero)
         special_res = {sa & sb, {(W-1){1'b0}}};
      else
         special = 1'b0;
   end

   // Alignment: flushed operands compare by {exp, frac}
   logic [W-2:0]      mag_a, mag_b, x_mag, y_mag;
   logic              a_big, x_sign, y_sign, x_hid, y_hid;
   logic [EXP_W-1:0]  x_exp, y_exp, dexp;
   int                shamt;
   logic [2*MW4-1:0]  y_wide;
   logic [MW4-1:0]    y_al;

   assign mag_a  = a_zero ? '0 : a_q[W-2:0];
   assign mag_b  = b_zero ? '0 : b_q[W-2:0];
   assign a_big  = (mag_a >= mag_b);
   assign x_mag  = a_big ? mag_a : mag_b;
   assign y_mag  = a_big ? mag_b : mag_a;
   assign x_sign = a_big ? sa : sb;
   assign y_sign = a_big ? sb : sa;
   assign x_exp  = x_mag[W-2:MAN_W];
   assign y_exp  = y_mag[W-2:MAN_W];
   assign x_hid  = |x_exp;
   assign y_hid  = |y_exp;
   assign dexp   = x_exp - y_exp;
   assign shamt  = (int'(dexp) > MW4) ? MW4 : int'(dexp);
   assign y_wide = {y_hid, y_mag[MAN_W-1:0], 3'b000, {MW4{1'b0}}} >> shamt;
   assign y_al   = {y_wide[2*MW4-1:MW4+1], y_wide[MW4] | (|y_wide[MW4-1:0])};

   logic [MW4:0] sum_c;
   assign sum_c = eff_sub ? ({1'b0, x_m} - {1'b0, y_m}) : ({1'b0, x_m} + {1'b0, y_m});

   logic [SH_W-1:0] lz;
   logic [MW4-1:0]  norm_l, norm_c;
   logic            uf_c;

   assign lz     = lzc(sum_r[MW4-1:0]);
   assign norm_l = sum_r[MW4-1:0] << lz;
   assign norm_c = {sum_r[MW4:2], sum_r[1] | sum_r[0]};
   assign uf_c   = int'(exp_r) <= int'(lz);

   logic [MAN_W:0]   mant;
   logic             inc, rcarry, ovf;
   logic [MAN_W+1:0] mant_rnd;
   logic [EW1-1:0]   exp_rnd;
   logic [MAN_W-1:0] frac_rnd;

   assign mant     = norm_m[MW4-1:3];
   assign inc      = norm_m[2] & (norm_m[1] | norm_m[0] | mant[0]);
   assign mant_rnd = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
   assign rcarry   = mant_rnd[MAN_W+1];
   assign exp_rnd  = exp_r + {{EXP_W{1'b0}}, rcarry};
   assign frac_rnd = rcarry ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
   assign ovf      = exp_rnd >= {1'b0, ONES};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sign_r    <= 1'b0;
         eff_sub   <= 1'b0;
         uf_r      <= 1'b0;
         exp_r     <= '0;
         x_m       <= '0;
         y_m       <= '0;
         norm_m    <= '0;
         sum_r     <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               a_q       <= op_a;
               b_q       <= {op_b[W-1] ^ sub, op_b[W-2:0]};
               overflow  <= 1'b0;
               underflow <= 1'b0;
               invalid   <= 1'b0;
               in_ready  <= 1'b0;
               state     <= S_UNPACK;
            end
            S_UNPACK: if (special) begin
               result  <= special_res;
               invalid <= special_inv;
               state   <= S_DONE;
            end else begin
               state <= S_ALIGN;
            end
            S_ALIGN: begin
               x_m     <= {x_hid, x_mag[MAN_W-1:0], 3'b000};
               y_m     <= y_al;
               exp_r   <= {1'b0, x_exp};
               sign_r  <= x_sign;
               eff_sub <= x_sign ^ y_sign;
               state   <= S_ADD;
            end
            S_ADD: if (sum_c == '0) begin
               result <= '0;
               state  <= S_DONE;
            end else begin
               sum_r <= sum_c;
               state <= S_NORM;
            end
            S_NORM: begin
               if (sum_r[MW4]) begin
                  norm_m <= norm_c;
                  exp_r  <= exp_r + E_ONE;
                  uf_r   <= 1'b0;
               end else if (uf_c) begin
                  uf_r <= 1'b1;
               end else begin
                  norm_m <= norm_l;
                  exp_r  <= exp_r - EW1'(lz);
                  uf_r   <= 1'b0;
               end
               state <= S_ROUND;
            end
            S_ROUND: begin
               if (uf_r) begin
                  result    <= {sign_r, {(W-1){1'b0}}};
                  underflow <= 1'b1;
               end else if (ovf) begin
                  result   <= {sign_r, ONES, {MAN_W{1'b0}}};
                  overflow <= 1'b1;
               end else begin
                  result <= {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
               end
               state <= S_DONE;
            end
            S_DONE: if (out_valid && out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= S_IDLE;
            end else begin
               out_valid <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed cases, handshake/reset scenarios and random
// operands checked against an exact-arithmetic reference model (single and half width).
module tb_fp_addsub_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, sub, out_valid, out_ready;
   logic        overflow, underflow, invalid;
   logic [31:0] op_a, op_b, result;
   logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
   logic        h_overflow, h_underflow, h_invalid;
   logic [15:0] h_op_a, h_op_b, h_result;

   int n_tests = 0;
   int n_fail  = 0;

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .overflow(overflow),
      .underflow(underflow), .invalid(invalid));

   fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .op_a(h_op_a), .op_b(h_op_b), .sub(h_sub), .out_valid(h_out_valid),
      .out_ready(h_out_ready), .result(h_result), .overflow(h_overflow),
      .underflow(h_underflow), .invalid(h_invalid));

   // Exact reference: integer mantissas scaled to a common exponent, then rounded once.
   function automatic void model(input longint a, input longint b, input bit s,
                                 input int ew, input int mw,
                                 output longint res, output logic [2:0] fl);
      longint one, maxe, mmask, qnan, ea, eb, fa, fb, sa, sb;
      longint ma, mb, emin, sum, mag, q, r, half, e;
      int p, sh;
      bit sg;
      one   = 1;
      maxe  = (one << ew) - 1;
      mmask = (one << mw) - 1;
      sa = (a >> (ew + mw)) & 1;  ea = (a >> mw) & maxe;  fa = a & mmask;
      sb = ((b >> (ew + mw)) & 1) ^ longint'(s);
      eb = (b >> mw) & maxe;  fb = b & mmask;
      qnan = (maxe << mw) | (one << (mw - 1));
      fl  = 3'b000;
      res = 0;
      if ((ea == maxe && fa != 0) || (eb == maxe && fb != 0)) res = qnan;
      else if (ea == maxe && eb == maxe) begin
         if (sa != sb) begin res = qnan; fl = 3'b001; end
         else res = (sa << (ew + mw)) | (maxe << mw);
      end
      else if (ea == maxe) res = (sa << (ew + mw)) | (maxe << mw);
      else if (eb == maxe) res = (sb << (ew + mw)) | (maxe << mw);
      else if (ea == 0 && eb == 0) res = (sa & sb) << (ew + mw);
      else if (ea == 0) res = (sb << (ew + mw)) | (eb << mw) | fb;
      else if (eb == 0) res = (sa << (ew + mw)) | (ea << mw) | fa;
      else begin
         emin = (ea < eb) ? ea : eb;
         ma   = ((one << mw) | fa) << (ea - emin);
         mb   = ((one << mw) | fb) << (eb - emin);
         sum  = ((sa != 0) ? -ma : ma) + ((sb != 0) ? -mb : mb);
         if (sum != 0) begin
            sg  = (sum < 0);
            mag = sg ? -sum : sum;
            p   = 0;
            for (int i = 0; i < 63; i++) if (mag[i]) p = i;
            e = emin + p - mw;
            if (e <= 0) begin
               res = longint'(sg) << (ew + mw);
               fl  = 3'b010;
            end else begin
               if (p > mw) begin
                  sh   = p - mw;
                  q    = mag >> sh;
                  r    = mag & ((one << sh) - 1);
                  half = one << (sh - 1);
                  if (r > half || (r == half && q[0])) q = q + 1;
                  if (q == (one << (mw + 1))) begin q = q >> 1; e = e + 1; end
               end else begin
                  q = mag << (mw - p);
               end
               if (e >= maxe) begin
                  res = (longint'(sg) << (ew + mw)) | (maxe << mw);
                  fl  = 3'b100;
               end else begin
                  res = (longint'(sg) << (ew + mw)) | (e << mw) | (q & mmask);
               end
            end
         end
      end
   endfunction

   task automatic gen(input int ew, input int mw, output logic [31:0] a,
                      output logic [31:0] b, output bit s);
      int maxn, span, ea, eb;
      logic [31:0] mask, fa, fb, sa, sb;
      maxn = (1 << ew) - 2;
      span = mw + 7;
      mask = (32'd1 << mw) - 32'd1;
      ea = int'($urandom_range(1, maxn));
      eb = ea + int'($urandom_range(0, 2 * span)) - span;
      if (eb < 1) eb = 1;
      if (eb > maxn) eb = maxn;
      fa = $urandom & mask;
      fb = $urandom & mask;
      if ($urandom_range(0, 3) == 0) begin
         eb = ea;
         fb = fa ^ ($urandom & 32'hF & mask);
      end
      sa = 32'($urandom_range(0, 1));
      sb = 32'($urandom_range(0, 1));
      a = (sa << (ew + mw)) | (32'(ea) << mw) | fa;
      b = (sb << (ew + mw)) | (32'(eb) << mw) | fb;
      s = bit'($urandom_range(0, 1));
   endtask

   // Drives one operation through the selected instance and consumes the result.
   task automatic do_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                        input bit s, output logic [31:0] res, output logic [2:0] fl,
                        output int lat, output bit to);
      int k;
      to = 1'b0; lat = 0; res = '0; fl = '0;
      @(negedge clk);
      if (h) begin h_op_a = a[15:0]; h_op_b = b[15:0]; h_sub = s; h_in_valid = 1'b1; end
      else   begin op_a = a; op_b = b; sub = s; in_valid = 1'b1; end
      k = 0;
      while (!(h ? h_in_ready : in_ready) && k < 20) begin @(negedge clk); k++; end
      if (!(h ? h_in_ready : in_ready)) begin
         to = 1'b1; in_valid = 1'b0; h_in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0; h_in_valid = 1'b0;
      op_a = $urandom; op_b = $urandom; h_op_a = 16'($urandom); h_op_b = 16'($urandom);
      k = 0;
      while (!(h ? h_out_valid : out_valid) && k < 30) begin @(negedge clk); k++; end
      lat = k;
      if (!(h ? h_out_valid : out_valid)) begin to = 1'b1; return; end
      res = h ? {16'h0, h_result} : result;
      fl  = h ? {h_overflow, h_underflow, h_invalid} : {overflow, underflow, invalid};
      if (h) h_out_ready = 1'b1; else out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; h_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      n_tests++;
      if (result !== 32'h0 || {overflow, underflow, invalid} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: result=%h flags=%b, want 0/000",
                  result, {overflow, underflow, invalid});
      end
      n_tests++;
      if (h_in_ready !== 1'b1 || h_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_half: in_ready=%b out_valid=%b, want 1/0", h_in_ready, h_out_valid);
      end
   endtask

   task automatic test_basic();
      logic [31:0] r; logic [2:0] fl; int lat; bit to;
      do_op(1'b0, 32'h3F800000, 32'h3F800000, 1'b0, r, fl, lat, to);
      n_tests++;
      if (to || lat != 6) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d cycles (timeout=%b), want 6", lat, to);
      end
      n_tests++;
      if (r !== 32'h40000000 || fl !== 3'b000) begin
         n_fail++;
         $display("FAIL basic_result: got %h flags %b, want 40000000 flags 000", r, fl);
      end
   endtask

   typedef struct {
      logic [31:0] a, b;
      bit          s;
      logic [31:0] r;
      logic [2:0]  fl;
   } vec_t;

   task automatic test_directed();
      vec_t tbl [0:15];
      logic [31:0] r; logic [2:0] fl; int lat; bit to;
      tbl = '{
         '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},
         '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000},
         '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000},
         '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000},
         '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000},
         '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100},
         '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010},
         '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001},
         '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000},
         '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000},
         '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000},
         '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},
         '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000},
         '{32'h00000001, 32'h80000003, 1'b0, 32'h00000000, 3'b000},
         '{32'h3F800000, 32'h00000005, 1'b0, 32'h3F800000, 3'b000},
         '{32'hC0000000, 32'hBF800000, 1'b1, 32'hBF800000, 3'b000}
      };
      foreach (tbl[i]) begin
         do_op(1'b0, tbl[i].a, tbl[i].b, tbl[i].s, r, fl, lat, to);
         n_tests++;
         if (to || r !== tbl[i].r || fl !== tbl[i].fl) begin
            n_fail++;
            $display("FAIL directed_%0d: %h %s %h got %h flags %b (timeout=%b), want %h flags %b",
                     i, tbl[i].a, tbl[i].s ? "-" : "+", tbl[i].b, r, fl, to, tbl[i].r, tbl[i].fl);
         end
      end
   endtask

   task automatic test_random(input bit h, input int count);
      logic [31:0] a, b, r; logic [2:0] fl, mfl; int lat; bit to, s;
      longint mres;
      for (int i = 0; i < count; i++) begin
         gen(h ? 5 : 8, h ? 10 : 23, a, b, s);
         model(longint'(a), longint'(b), s, h ? 5 : 8, h ? 10 : 23, mres, mfl);
         do_op(h, a, b, s, r, fl, lat, to);
         n_tests++;
         if (to || r !== mres[31:0] || fl !== mfl) begin
            n_fail++;
            $display("FAIL random_%s_%0d: %h %s %h got %h flags %b (timeout=%b), want %h flags %b",
                     h ? "half" : "single", i, a, s ? "-" : "+", b, r, fl, to, mres[31:0], mfl);
         end
      end
   endtask

   task automatic test_back_to_back();
      int k; bit stable_ok;
      @(negedge clk);
      op_a = 32'h40400000; op_b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 30) begin @(negedge clk); k++; end
      n_tests++;
      if (out_valid !== 1'b1 || result !== 32'h40800000) begin
         n_fail++;
         $display("FAIL bp_first: out_valid=%b result=%h, want 1/40800000", out_valid, result);
      end
      stable_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (result !== 32'h40800000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            stable_ok = 1'b0;
            $display("FAIL bp_hold_cycle_%0d: result=%h in_ready=%b out_valid=%b, want 40800000/0/1",
                     c, result, in_ready, out_valid);
         end
      end
      n_tests++;
      if (!stable_ok) n_fail++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      op_a = 32'h40000000; op_b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 30) begin @(negedge clk); k++; end
      n_tests++;
      if (out_valid !== 1'b1 || result !== 32'h40400000 || {overflow, underflow, invalid} !== 3'b000) begin
         n_fail++;
         $display("FAIL b2b_second: out_valid=%b result=%h flags=%b, want 1/40400000/000",
                  out_valid, result, {overflow, underflow, invalid});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int k; bit seen;
      logic [31:0] r; logic [2:0] fl; int lat; bit to;
      @(negedge clk);
      op_a = 32'h3F800000; op_b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL reset_mid_no_output: out_valid seen=%b, want 0", seen);
      end
      do_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, r, fl, lat, to);
      n_tests++;
      if (to || r !== 32'h40400000 || fl !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid_recover: got %h flags %b (timeout=%b), want 40400000 flags 000",
                  r, fl, to);
      end
   endtask

   task automatic test_half();
      logic [31:0] r; logic [2:0] fl; int lat; bit to;
      do_op(1'b1, 32'h3C00, 32'h3C00, 1'b0, r, fl, lat, to);
      n_tests++;
      if (to || lat != 6 || r !== 32'h4000 || fl !== 3'b000) begin
         n_fail++;
         $display("FAIL half_one_plus_one: got %h flags %b lat %0d (timeout=%b), want 4000 flags 000 lat 6",
                  r, fl, lat, to);
      end
      do_op(1'b1, 32'h7BFF, 32'h7BFF, 1'b0, r, fl, lat, to);
      n_tests++;
      if (to || r !== 32'h7C00 || fl !== 3'b100) begin
         n_fail++;
         $display("FAIL half_overflow: got %h flags %b (timeout=%b), want 7C00 flags 100", r, fl, to);
      end
      do_op(1'b1, 32'h7C00, 32'h7C00, 1'b1, r, fl, lat, to);
      n_tests++;
      if (to || r !== 32'h7E00 || fl !== 3'b001) begin
         n_fail++;
         $display("FAIL half_invalid: got %h flags %b (timeout=%b), want 7E00 flags 001", r, fl, to);
      end
      test_random(1'b1, 60);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
      h_in_valid = 1'b0; h_sub = 1'b0; h_out_ready = 1'b0; h_op_a = '0; h_op_b = '0;
      test_reset();
      test_basic();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random(1'b0, 150);
      test_half();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on input and output. It generalises the single-precision combinational adder to arbitrary exponent and mantissa widths. It adds a subtract mode, guard/round/sticky rounding to nearest-even, special-value handling and separate exception flags. It sits between operand registers and the ALU result mux.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (hidden bit implicit)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and op present
in_ready  output  1  block can accept operands
op_a  input  1+EXP_W+MAN_W  operand A {sign, exp, frac}
op_b  input  1+EXP_W+MAN_W  operand B
sub  input  1  0: A+B, 1: A-B (B sign inverted)
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  1+EXP_W+MAN_W  rounded sum
overflow  output  1  finite inputs, rounded result exceeded max finite
underflow  output  1  nonzero exact result flushed to zero
invalid  output  1  inf - inf; result is canonical quiet NaN

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0. Reset mid-operation discards the operation; no partial output is produced.
- Handshake: an operation is accepted on the edge where in_valid&&in_ready. in_ready=1 only in IDLE. Operands are captured, so inputs may change after acceptance. The result is consumed on the edge where out_valid&&out_ready. The return to IDLE occurs on that edge. in_ready rises the following cycle (no same-cycle accept in DONE).
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE. Every state except IDLE and DONE lasts exactly one cycle. out_valid asserts 6 cycles after the accept edge and holds with stable result and flags until consumed.
- UNPACK: effective B sign = b.sign^sub. Denormal inputs (exp=0) are treated as signed zero (FTZ). Classify each operand as zero, finite, inf or NaN (exp all-ones, frac!=0). A special case sets a bypass flag and jumps directly to DONE on the next edge with that fixed result. Special results:
  - any NaN -> canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=0.
  - inf-inf (opposite effective signs) -> qNaN, invalid=1.
  - a single inf -> that inf.
  - both zero -> sign = AND of signs.
- ALIGN: swap operands so that the larger magnitude ({exp,frac} compare) is X. Shift Y's mantissa (hidden bit prepended) right by the exponent difference into a MAN_W+4-bit field (mantissa, guard, round, sticky). Shifted-out bits are ORed into sticky. A shift of at least MAN_W+3 leaves only the sticky bit.
- ADD: if effective signs are equal, add with one carry bit; otherwise compute X-Y, which is never negative. The result sign is X's sign. An exact zero difference gives +0 with no flags and goes straight to DONE.
- NORM:
  - carry: shift right 1 (keep sticky), exponent+1.
  - otherwise: left-shift by the leading-zero count in one cycle, decreasing the exponent.
  - if the exponent would drop to <=0: result = signed zero, underflow=1.
- ROUND:
  - round to nearest, ties to even, using guard and (round|sticky).
  - a mantissa carry-out renormalises and increments the exponent.
  - exponent >= all-ones after rounding: result = signed infinity, overflow=1.
- Flags are mutually exclusive and valid only while out_valid=1. They are cleared on acceptance of the next operation.

Test Plan:
- Reset, then 0x3F800000 + 0x3F800000 (sub=0) -> out_valid exactly 6 cycles after accept, result 0x40000000, flags 0.
- 0x3F800000 - 0x3F800000 (sub=1) -> 0x00000000; and 0x40400000 + 0xBF800000 -> 0x40000000.
- Rounding: 0x3F800000 + 0x33800000 (tie) -> 0x3F800000; 0x3F800000 + 0x33800001 -> 0x3F800001; 0x3F800001 + 0x33800000 -> 0x3F800002.
- Exceptions:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1.
  - 0x00800001 - 0x00800000 -> 0x00000000, underflow=1.
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1.
  - 0x7FC00001 + 1.0 -> 0x7FC00000, invalid=0.
- Back-pressure: hold out_ready=0 for 10 cycles -> result stable, in_ready=0 throughout. Pulse out_ready -> in_ready=1 on the next cycle; a back-to-back second op completes correctly.
- Reset asserted in the ADD state -> next cycle in_ready=1, out_valid=0, and no result emitted. Repeat with EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000.
